pc_fetch_unit: RTL and testbench

- Consumer side of the branch decision. Owns the program counter and fetches one instruction at a time from instruction memory over a req/ready handshake.
- Presents each instruction to the decode/execute stages and waits for that instruction to resolve (ex_valid).
- On resolution, loads either the branch target (pc_sel=1) or PC+4, then fetches again. Matches the sequential, one-instruction-in-flight processor.

---
 rtl/pc_fetch_pkg.sv | 15 +
 rtl/pc_fetch_unit_next_pc_gen.sv | 24 ++
 rtl/pc_fetch_unit.sv | 115 +++++++++++
 tb/tb_pc_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter fetch unit.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    ISSUE   = 2'd1,
    RESOLVE = 2'd2,
    HALT    = 2'd3
  } state_e;

  localparam int          PC_STEP          = 4;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_next_pc_gen.sv
// Next-PC selection (sequential step or branch target) and misaligned-target detect.
// Misalign detection exists only when MISALIGN_CHECK_EN is defined.
module next_pc_gen
  import pc_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_sel_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            misalign_o
);

  // The add wraps naturally at 2^XLEN.
  assign next_pc_o = pc_sel_i ? branch_target_i : pc_i + XLEN'(PC_STEP);

`ifdef MISALIGN_CHECK_EN
  assign misalign_o = pc_sel_i && (branch_target_i[1:0] != 2'b00);
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// Sequential one-instruction-in-flight fetch unit: fetch, issue to decode, wait for resolve.
// With MISALIGN_CHECK_EN defined, a misaligned taken target halts the unit until reset.
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc,
  input  logic               instr_ack,
  input  logic               ex_valid,
  input  logic               pc_sel,
  input  logic [XLEN-1:0]    branch_target,
  output logic [31:0]        retire_count,
  output logic               misalign_err
);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [XLEN-1:0]    instr_pc_q, instr_pc_d;
  logic [31:0]        retire_q, retire_d;
  logic               err_q, err_d;

  logic [XLEN-1:0]    next_pc;
  logic               misalign;

  next_pc_gen #(.XLEN(XLEN)) u_next_pc (
    .pc_i            (pc_q),
    .pc_sel_i        (pc_sel),
    .branch_target_i (branch_target),
    .next_pc_o       (next_pc),
    .misalign_o      (misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retire_d   = retire_q;
    err_d      = err_q;
    case (state_q)
      FETCH: begin
        // Ready only completes a request actually on the bus (req low right after reset).
        if (req_q && imem_ready) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ack) state_d = RESOLVE;
      end
      RESOLVE: begin
        if (ex_valid) begin
          retire_d = retire_q + 32'd1;
          if (misalign) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    // Handshake outputs are registered copies of the state being entered.
    req_d   = (state_d == FETCH);
    valid_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      retire_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      retire_q   <= retire_d;
      err_q      <= err_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr_valid  = valid_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign retire_count = retire_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized scoreboard bench for pc_fetch_unit; reference model tracks the PC stream arithmetically.
module tb_pc_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ack;
  logic        ex_valid;
  logic        pc_sel;
  logic [31:0] branch_target;
  logic [31:0] retire_count;
  logic        misalign_err;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  logic [31:0] exp_ret_q[$];
  logic [31:0] model_pc;
  logic [31:0] model_count;
  bit   model_halted;
  bit   ex_real;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ack     (instr_ack),
    .ex_valid      (ex_valid),
    .pc_sel        (pc_sel),
    .branch_target (branch_target),
    .retire_count  (retire_count),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout waiting for DUT, expected event within budget", name);
  endtask

  // Monitor: pops the scoreboard on every decode handshake and retire.
  logic        prev_req, prev_ready, prev_valid, prev_ack;
  logic [31:0] prev_addr, prev_instr, prev_ipc;
  bit          ret_pend = 0;

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] r;
    if (!reset) begin
      if (ret_pend) begin
        ret_pend = 0;
        if (exp_ret_q.size() == 0) timeout_fail("retire_queue_empty");
        else begin
          r = exp_ret_q.pop_front();
          check("retire_count", retire_count, r);
        end
      end
      if (ex_real && ex_valid) ret_pend = 1;
      if (imem_req && imem_ready) begin
        if (exp_q.size() == 0) timeout_fail("fetch_unexpected");
        else check("imem_addr", imem_addr, exp_q[0].pc);
      end
      if (instr_valid && instr_ack) begin
        if (exp_q.size() == 0) timeout_fail("issue_unexpected");
        else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.ins);
        end
      end
      if (prev_req && imem_req && !(prev_ready))
        check("addr_stable", imem_addr, prev_addr);
      if (prev_valid && instr_valid && !prev_ack) begin
        check("instr_stable", instr, prev_instr);
        check("instr_pc_stable", instr_pc, prev_ipc);
      end
    end
    prev_req   = imem_req;
    prev_ready = imem_ready;
    prev_valid = instr_valid;
    prev_ack   = instr_ack;
    prev_addr  = imem_addr;
    prev_instr = instr;
    prev_ipc   = instr_pc;
  end

  // mode 0: random resolve, 1: sequential, 2: taken to ftgt
  task automatic run_instr(input int mode, input logic [31:0] ftgt);
    int n;
    int d;
    logic sel;
    logic [31:0] tgt;
    n = 0;
    while (!imem_req && n < 50) begin @(posedge clk); #1; n++; end
    if (!imem_req) begin timeout_fail("imem_req_wait"); return; end
    d = $urandom_range(0, 5);
    repeat (d) begin
      imem_rdata = $urandom;
      instr_ack  = 1'($urandom_range(0, 1));
      ex_valid   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    instr_ack  = 1'b0;
    ex_valid   = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = mem_word(imem_addr);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    n = 0;
    while (!instr_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!instr_valid) begin timeout_fail("instr_valid_wait"); return; end
    d = $urandom_range(0, 4);
    repeat (d) begin
      // Spurious resolve strobes while waiting for decode must be ignored.
      ex_valid      = ($urandom_range(0, 2) == 0);
      pc_sel        = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      imem_ready    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    ex_valid   = 1'b0;
    imem_ready = 1'b0;
    instr_ack  = 1'b1;
    @(posedge clk); #1;
    instr_ack = 1'b0;
    d = $urandom_range(0, 3);
    repeat (d) begin
      imem_ready = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      pc_sel     = 1'($urandom_range(0, 1));
      instr_ack  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    imem_ready = 1'b0;
    instr_ack  = 1'b0;
    tgt = $urandom;
    tgt[1:0] = 2'b00;
    sel = ($urandom_range(0, 2) == 0);
    if (mode == 1) sel = 1'b0;
    if (mode == 2) begin sel = 1'b1; tgt = ftgt; end
    ex_valid      = 1'b1;
    pc_sel        = sel;
    branch_target = tgt;
    ex_real       = 1'b1;
    model_count   = model_count + 32'd1;
    exp_ret_q.push_back(model_count);
`ifdef MISALIGN_CHECK_EN
    if (sel && tgt[1:0] != 2'b00) model_halted = 1;
`endif
    if (!model_halted) begin
      model_pc = sel ? tgt : model_pc + 32'd4;
      exp_q.push_back('{pc: model_pc, ins: mem_word(model_pc)});
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
    ex_real  = 1'b0;
    pc_sel   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
    ex_valid = 1'b0; pc_sel = 1'b0; branch_target = '0; ex_real = 1'b0;
    model_pc = TB_RESET_PC; model_count = '0; model_halted = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", imem_addr, TB_RESET_PC);
    check("rst_retire", retire_count, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    @(posedge clk); #1;
    check("req_after_release", {31'd0, imem_req}, 32'd1);
    // Reset in the middle of a pending fetch; a late ready must not be taken.
    #2 reset = 1'b1;
    #1;
    check("req_async_clear", {31'd0, imem_req}, 32'd0);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    check("req_after_rst2", {31'd0, imem_req}, 32'd1);
    check("instr_valid_after_rst2", {31'd0, instr_valid}, 32'd0);
    check("addr_after_rst2", imem_addr, TB_RESET_PC);

    exp_q.push_back('{pc: model_pc, ins: mem_word(model_pc)});
    repeat (4) run_instr(1, 32'd0);     // crosses 0xFFFFFFFC -> 0x0
    run_instr(2, 32'h0000_0040);
    repeat (30) run_instr(0, 32'd0);
    run_instr(2, 32'h0000_0042);
`ifdef MISALIGN_CHECK_EN
    repeat (5) @(posedge clk);
    #1;
    check("halt_req", {31'd0, imem_req}, 32'd0);
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_err", {31'd0, misalign_err}, 32'd1);
    check("halt_retire", retire_count, model_count);
`else
    run_instr(0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("no_misalign_err", {31'd0, misalign_err}, 32'd0);
    check("final_retire", retire_count, model_count);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
